// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - fetch unit bundle: memory read channel, decode handoff, next-PC input
interface inst_fetch_unit_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        inst_fault;
   logic [31:0] npc;
   logic        npc_valid;
   logic [31:0] fetch_cnt;

   modport master (
      output araddr, arvalid, rready, inst, pc, inst_valid, inst_fault, fetch_cnt,
      input  arready, rdata, rresp, rvalid, inst_ready, npc, npc_valid
   );

   modport slave (
      input  araddr, arvalid, rready, inst, pc, inst_valid, inst_fault, fetch_cnt,
      output arready, rdata, rresp, rvalid, inst_ready, npc, npc_valid
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - multi-cycle RV32E instruction fetch stage
module inst_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
   parameter logic [31:0] FAULT_INST   = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               rst,
   inst_fetch_unit_if.master  bus
);
   typedef enum logic [2:0] {BOOT, REQ, RESP, OUT, WAIT_NPC} state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic        fault_q;
   logic [31:0] cnt_q;
   logic        arvalid;
   logic        rready;
   logic        inst_valid;

   always_ff @(posedge clk) begin
      if (rst) state <= BOOT;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         BOOT:     state_next = REQ;
         REQ:      if (bus.arready)    state_next = RESP;
         RESP:     if (bus.rvalid)     state_next = OUT;
         OUT:      if (bus.inst_ready) state_next = WAIT_NPC;
         WAIT_NPC: if (bus.npc_valid)  state_next = (bus.npc[1:0] == 2'b00) ? REQ : OUT;
         default:  state_next = BOOT;
      endcase
   end

   always_comb begin
      arvalid    = (state == REQ);
      rready     = (state == RESP);
      inst_valid = (state == OUT);
   end

   // A misaligned npc skips the bus entirely and reports a fault for that PC.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_VECTOR;
         inst_q  <= FAULT_INST;
         fault_q <= 1'b0;
         cnt_q   <= 32'd0;
      end else begin
         case (state)
            RESP: begin
               if (bus.rvalid) begin
                  if (bus.rresp == 2'b00) begin
                     inst_q  <= bus.rdata;
                     fault_q <= 1'b0;
                  end else begin
                     inst_q  <= FAULT_INST;
                     fault_q <= 1'b1;
                  end
               end
            end
            OUT: begin
               if (bus.inst_ready) cnt_q <= cnt_q + 32'd1;
            end
            WAIT_NPC: begin
               if (bus.npc_valid) begin
                  pc_q <= bus.npc;
                  if (bus.npc[1:0] != 2'b00) begin
                     inst_q  <= FAULT_INST;
                     fault_q <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.araddr     = pc_q;
   assign bus.arvalid    = arvalid;
   assign bus.rready     = rready;
   assign bus.inst       = inst_q;
   assign bus.pc         = pc_q;
   assign bus.inst_valid = inst_valid;
   assign bus.inst_fault = fault_q;
   assign bus.fetch_cnt  = cnt_q;
endmodule
